// File: rtl/peak_extractor_if.sv
// Peak result handshake bundle between peak_extractor and its consumer.
interface peak_extractor_if #(
    parameter int WIDTH = 16
);
    logic             peak_valid;
    logic             peak_ready;
    logic [WIDTH-1:0] Vc_peak;
    logic [WIDTH-1:0] Ic_peak;

    modport master (
        output peak_valid,
        output Vc_peak,
        output Ic_peak,
        input  peak_ready
    );

    modport slave (
        input  peak_valid,
        input  Vc_peak,
        input  Ic_peak,
        output peak_ready
    );
endinterface

// File: rtl/peak_extractor.sv
// Per-window |Vc| / |Ic| peak tracker with a one-entry valid/ready output slot.
// Define PEAK_ZC_SYNC_EN to align windows to rising Vc zero crossings.
module peak_extractor #(
    parameter int WIDTH   = 16,
    parameter int SPC     = 64,
    parameter int MAX_LEN = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] Vc_sample,
    input  logic signed [WIDTH-1:0] Ic_sample,
    output logic                    overrun,
    peak_extractor_if.master        pk
);
    localparam int LEN = (MAX_LEN > SPC) ? MAX_LEN : SPC;
    localparam int CW  = $clog2(LEN);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Saturating magnitude: the most-negative code maps to the largest positive.
    function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
        if (x == NEG_MIN)
            return POS_MAX;
        else if (x[WIDTH-1])
            return -x;
        else
            return x;
    endfunction

    function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] vc_max_q, vc_max_d;
    logic [WIDTH-1:0] ic_max_q, ic_max_d;
    logic             pv_q, pv_d;
    logic [WIDTH-1:0] vc_pk_q, vc_pk_d;
    logic [WIDTH-1:0] ic_pk_q, ic_pk_d;
    logic             ovr_q, ovr_d;

    logic             accept;
    logic             close_c;
    logic [WIDTH-1:0] vc_abs, ic_abs;
    logic [WIDTH-1:0] vc_base, ic_base;
    logic [WIDTH-1:0] vc_new, ic_new;
    logic [WIDTH-1:0] res_vc, res_ic;

    assign accept  = en & sample_valid;
    assign vc_abs  = sat_abs(Vc_sample);
    assign ic_abs  = sat_abs(Ic_sample);
    assign vc_base = (state_q == ACCUM) ? vc_max_q : '0;
    assign ic_base = (state_q == ACCUM) ? ic_max_q : '0;
    assign vc_new  = umax(vc_base, vc_abs);
    assign ic_new  = umax(ic_base, ic_abs);

    assign state_d = en ? ACCUM : IDLE;

`ifdef PEAK_ZC_SYNC_EN
    logic have_prev_q, have_prev_d;
    logic prev_neg_q, prev_neg_d;
    logic started_q, started_d;
    logic crossing;

    assign crossing = have_prev_q & prev_neg_q & ~Vc_sample[WIDTH-1];

    always_comb begin
        cnt_d       = cnt_q;
        vc_max_d    = vc_max_q;
        ic_max_d    = ic_max_q;
        have_prev_d = have_prev_q;
        prev_neg_d  = prev_neg_q;
        started_d   = started_q;
        close_c     = 1'b0;
        res_vc      = vc_new;
        res_ic      = ic_new;
        if (!en) begin
            cnt_d       = '0;
            vc_max_d    = '0;
            ic_max_d    = '0;
            have_prev_d = 1'b0;
            started_d   = 1'b0;
        end else if (accept) begin
            have_prev_d = 1'b1;
            prev_neg_d  = Vc_sample[WIDTH-1];
            if (crossing) begin
                // Crossing sample ends the old window and seeds the new one.
                close_c   = started_q;
                res_vc    = vc_base;
                res_ic    = ic_base;
                started_d = 1'b1;
                cnt_d     = '0;
                vc_max_d  = vc_abs;
                ic_max_d  = ic_abs;
            end else if (started_q) begin
                if (cnt_q == CW'(MAX_LEN - 1)) begin
                    close_c  = 1'b1;
                    cnt_d    = '0;
                    vc_max_d = '0;
                    ic_max_d = '0;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    vc_max_d = vc_new;
                    ic_max_d = ic_new;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev_q <= 1'b0;
            prev_neg_q  <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            have_prev_q <= have_prev_d;
            prev_neg_q  <= prev_neg_d;
            started_q   <= started_d;
        end
    end
`else
    always_comb begin
        cnt_d    = cnt_q;
        vc_max_d = vc_max_q;
        ic_max_d = ic_max_q;
        close_c  = 1'b0;
        res_vc   = vc_new;
        res_ic   = ic_new;
        if (!en) begin
            cnt_d    = '0;
            vc_max_d = '0;
            ic_max_d = '0;
        end else if (accept) begin
            if (cnt_q == CW'(SPC - 1)) begin
                close_c  = 1'b1;
                cnt_d    = '0;
                vc_max_d = '0;
                ic_max_d = '0;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                vc_max_d = vc_new;
                ic_max_d = ic_new;
            end
        end
    end
`endif

    // Output slot: loads when free, otherwise the new result is dropped.
    always_comb begin
        pv_d    = pv_q;
        vc_pk_d = vc_pk_q;
        ic_pk_d = ic_pk_q;
        ovr_d   = ovr_q;
        if (close_c && (!pv_q || pk.peak_ready)) begin
            pv_d    = 1'b1;
            vc_pk_d = res_vc;
            ic_pk_d = res_ic;
        end else begin
            if (close_c)
                ovr_d = 1'b1;
            if (pv_q && pk.peak_ready)
                pv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vc_max_q <= '0;
            ic_max_q <= '0;
            pv_q     <= 1'b0;
            vc_pk_q  <= '0;
            ic_pk_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vc_max_q <= vc_max_d;
            ic_max_q <= ic_max_d;
            pv_q     <= pv_d;
            vc_pk_q  <= vc_pk_d;
            ic_pk_q  <= ic_pk_d;
            ovr_q    <= ovr_d;
        end
    end

    assign pk.peak_valid = pv_q;
    assign pk.Vc_peak    = vc_pk_q;
    assign pk.Ic_peak    = ic_pk_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_peak_extractor.sv
// Directed scoreboard bench for peak_extractor (SPC=4, MAX_LEN=8).
module tb_peak_extractor;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                sample_valid = 1'b0;
    logic signed [W-1:0] Vc_sample = '0;
    logic signed [W-1:0] Ic_sample = '0;
    logic                overrun;

    peak_extractor_if #(.WIDTH(W)) pif ();

    peak_extractor #(
        .WIDTH(W),
        .SPC(4),
        .MAX_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sample_valid(sample_valid),
        .Vc_sample(Vc_sample),
        .Ic_sample(Ic_sample),
        .overrun(overrun),
        .pk(pif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_vc[$];
    int exp_ic[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic expect_res(input int vc, input int ic);
        exp_vc.push_back(vc);
        exp_ic.push_back(ic);
    endtask

    // Monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && pif.peak_valid && pif.peak_ready) begin
            if (exp_vc.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("sb_vc_peak", int'(pif.Vc_peak), exp_vc.pop_front());
                chk("sb_ic_peak", int'(pif.Ic_peak), exp_ic.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int vc, input int ic);
        en           = 1'b1;
        sample_valid = 1'b1;
        Vc_sample    = W'(vc);
        Ic_sample    = W'(ic);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        pif.peak_ready = 1'b1;
        do_reset();
        chk("rst_valid", int'(pif.peak_valid), 0);
        chk("rst_vc", int'(pif.Vc_peak), 0);
        chk("rst_ic", int'(pif.Ic_peak), 0);
        chk("rst_overrun", int'(overrun), 0);

`ifndef PEAK_ZC_SYNC_EN
        // Basic close with one-cycle valid pulse
        expect_res(3000, 20000);
        send(1000, 10000);
        send(-3000, -20000);
        send(2000, 5000);
        chk("basic_valid_pre", int'(pif.peak_valid), 0);
        send(500, 0);
        chk("basic_valid", int'(pif.peak_valid), 1);
        tick();
        chk("basic_valid_fall", int'(pif.peak_valid), 0);

        // Most-negative code saturates
        expect_res(32767, 100);
        send(-32768, 100);
        send(5, 100);
        send(-5, 100);
        send(0, 100);
        chk("sat_vc", int'(pif.Vc_peak), 32767);
        tick();

        // Backpressure holds first result, drops second
        pif.peak_ready = 1'b0;
        expect_res(1000, 1);
        send(1000, 1);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        chk("bp_valid", int'(pif.peak_valid), 1);
        chk("bp_vc_first", int'(pif.Vc_peak), 1000);
        send(2000, 2);
        send(0, 0);
        send(0, 0);
        send(0, 0);
        chk("bp_vc_held", int'(pif.Vc_peak), 1000);
        chk("bp_overrun", int'(overrun), 1);
        pif.peak_ready = 1'b1;
        tick();
        chk("bp_valid_fall", int'(pif.peak_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);

        // Enable drop aborts the partial window
        expect_res(700, 7);
        send(5000, 50);
        send(5000, 50);
        en = 1'b0;
        tick();
        send(700, 7);
        send(700, 7);
        send(700, 7);
        send(700, 7);
        chk("abort_vc", int'(pif.Vc_peak), 700);
        tick();

        // Reset while a result is pending and overrun is set
        pif.peak_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(900, 9);
        chk("pre_rst_valid", int'(pif.peak_valid), 1);
        do_reset();
        chk("mrst_valid", int'(pif.peak_valid), 0);
        chk("mrst_vc", int'(pif.Vc_peak), 0);
        chk("mrst_ic", int'(pif.Ic_peak), 0);
        chk("mrst_overrun", int'(overrun), 0);
        pif.peak_ready = 1'b1;
        expect_res(123, 456);
        send(-123, 4);
        send(12, -456);
        send(0, 0);
        send(1, 1);
        tick();
`else
        // Zero-crossing window then timeout close
        expect_res(400, 5);
        send(-10, 1);
        send(20, 2);
        send(300, 3);
        send(-400, 4);
        send(-5, 5);
        chk("zc_valid_pre", int'(pif.peak_valid), 0);
        send(6, 6);
        chk("zc_valid", int'(pif.peak_valid), 1);
        expect_res(80, 6);
        for (int i = 1; i <= 7; i++) send(i * 10, 1);
        chk("zc_no_early", int'(pif.peak_valid), 0);
        send(80, 1);
        chk("zc_timeout_valid", int'(pif.peak_valid), 1);
        chk("zc_overrun", int'(overrun), 0);
        tick();
`endif
        en = 1'b0;
        tick();
        tick();
        chk("sb_drained", exp_vc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/peak_extractor.md
Name: peak_extractor

Overview:
- Streaming front end that produces the Vc_peak / Ic_peak operand pair consumed by fault_classifier.
- Takes per-sample signed voltage and current values from the ADC path and tracks the maximum absolute value of each over one power-line cycle window.
- Presents the window peaks with a valid/ready handshake.
- Sits between the sample acquisition stage and the fault classifier.

Parameters:
- WIDTH, 16, sample and peak width (signed two's complement).
- SPC, 64, accepted samples per window (one mains cycle); legal range 2..65535.
- MAX_LEN, 128, window timeout in samples, used only with PEAK_ZC_SYNC_EN; must be greater than SPC.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  acquisition enable.
- sample_valid  in  1  Vc_sample / Ic_sample valid this cycle; there is no backpressure on the input.
- Vc_sample  in  WIDTH  signed phase-C voltage sample.
- Ic_sample  in  WIDTH  signed phase-C current sample.
- peak_valid  out  1  Vc_peak / Ic_peak hold a completed window result.
- peak_ready  in  1  consumer accepts the result.
- Vc_peak  out  WIDTH  signed; value is always in 0..2^(WIDTH-1)-1.
- Ic_peak  out  WIDTH  signed; same range.
- overrun  out  1  sticky flag: a window result was dropped.

Behaviour:
- Reset:
  - peak_valid=0, Vc_peak=0, Ic_peak=0, overrun=0.
  - Sample counter=0, both accumulators=0.
  - Any partial window is discarded.
- Accepted sample: en=1 and sample_valid=1 at a rising edge.
- Absolute value:
  - |x| for x >= -(2^(WIDTH-1)-1).
  - The most-negative code -32768 saturates to 32767.
  - No other wrap is permitted.
- Accumulate:
  - vc_max <= max(vc_max, |Vc_sample|).
  - ic_max <= max(ic_max, |Ic_sample|).
  - Counter increments by 1 per accepted sample.
- Window close (free-running mode):
  - Occurs on the accepted sample with counter==SPC-1.
  - Result = max of the accumulators and that final sample.
  - Accumulators and counter clear in the same edge.
  - The next accepted sample starts the new window with no gap.
- Output slot is free when peak_valid==0, or when peak_valid & peak_ready at that edge.
- Close with a free slot:
  - Result is registered into Vc_peak / Ic_peak.
  - peak_valid=1 in the cycle after the closing sample's edge (latency 1 cycle).
- Close with an occupied slot (peak_valid=1, peak_ready=0):
  - New result is dropped and the held output is unchanged.
  - overrun<=1, and stays 1 until rst.
- Handshake:
  - Transfer occurs on an edge with peak_valid & peak_ready.
  - Without a simultaneous close, peak_valid falls the next cycle.
  - With a simultaneous close, the new result loads and peak_valid stays 1 (back-to-back results).
  - Vc_peak / Ic_peak are stable while peak_valid & !peak_ready.
  - Vc_peak / Ic_peak are not cleared after transfer; they hold the last value.
- en=0:
  - Samples are ignored.
  - Counter and accumulators clear, aborting any partial window.
  - A pending result and its handshake proceed normally.
- sample_valid=0 with en=1: state holds; gaps within a window are allowed.
- FSM:
  - IDLE: en=0 or after rst.
  - ACCUM: en=1.
  - Transitions: IDLE->ACCUM when en=1; ACCUM->IDLE when en=0; rst forces IDLE from any state.
  - The output slot is an independent EMPTY/FULL register driving peak_valid.

Optional Feature:
- Macro: PEAK_ZC_SYNC_EN.
- Defined (zero-crossing sync):
  - Window boundaries align to the rising zero crossing of Vc: previous accepted Vc_sample <0 and current >=0.
  - The crossing sample closes the current window and is the first sample of the next one.
  - The first crossing after rst or en rising only starts a window; nothing is emitted.
  - If the counter reaches MAX_LEN-1 without a crossing, the window force-closes exactly as in free-running mode.
  - SPC is unused.
- Undefined: free-running SPC-sample windows as above; no crossing logic is synthesised.

Test Plan:
- Basic close: SPC=4, peak_ready=1, en=1; Vc=1000,-3000,2000,500 and Ic=10000,-20000,5000,0 -> peak_valid high for exactly 1 cycle, the cycle after the 4th sample; Vc_peak=3000, Ic_peak=20000.
- Saturation: SPC=4; Vc_sample=-32768 once, Ic all 100 -> Vc_peak=32767, Ic_peak=100, no wrap to negative.
- Backpressure: SPC=4, peak_ready=0; windows with Vc peaks 1000 then 2000 -> first window's output (Vc_peak=1000) held stable; second result dropped; overrun=1. Raising peak_ready -> transfer of 1000, then peak_valid=0; overrun still 1.
- Enable abort: en=0 after 2 samples of Vc=5000 (1 cycle), then 4 samples of Vc=700 -> single result Vc_peak=700; no result containing 5000.
- Reset mid-operation: rst asserted with peak_valid=1 and overrun=1 -> next cycle all outputs 0; following full window produces a normal result.
- PEAK_ZC_SYNC_EN, MAX_LEN=8:
  - Vc=-10,20,300,-400,-5,6 -> result Vc_peak=400 after sample 6.
  - Then 8 samples with no crossing -> timeout close on the 8th.
